// File: rtl/mach_v_bus_pkg.sv
// Shared constants for the mach-v memory bus.
// Holds the owner encodings, which double as the arbiter state encoding,
// and the default address/data widths and starvation limit.
package mach_v_bus_pkg;

  localparam int ADDR_W_DEF       = 32;
  localparam int DATA_W_DEF       = 32;
  localparam int STARVE_LIMIT_DEF = 4;

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_I    = 2'b01;
  localparam logic [1:0] OWN_D    = 2'b10;

  // The arbiter state is the registered owner, so Owner is the state itself.
  typedef enum logic [1:0] {
    IDLE  = OWN_NONE,
    GNT_I = OWN_I,
    GNT_D = OWN_D
  } state_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for mem_port_arbiter: fetch port (I_*), data port (D_*),
// memory port (M_*) and the Owner indication.
//   slave  : arbiter view (takes I/D requests and memory responses,
//            drives acks, read data, memory request and Owner)
//   master : environment view (core ports plus memory model)
interface mem_port_arbiter_if
  import mach_v_bus_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic                  I_req;
  logic [ADDR_W-1:0]     I_addr;
  logic [DATA_W-1:0]     I_rdata;
  logic                  I_ack;

  logic                  D_req;
  logic [DATA_W/8-1:0]   D_we;
  logic [ADDR_W-1:0]     D_addr;
  logic [DATA_W-1:0]     D_wdata;
  logic [DATA_W-1:0]     D_rdata;
  logic                  D_ack;

  logic                  M_req;
  logic [DATA_W/8-1:0]   M_we;
  logic [ADDR_W-1:0]     M_addr;
  logic [DATA_W-1:0]     M_wdata;
  logic [DATA_W-1:0]     M_rdata;
  logic                  M_ack;

  logic [1:0]            Owner;

  modport slave (
    input  I_req, I_addr, D_req, D_we, D_addr, D_wdata, M_rdata, M_ack,
    output I_rdata, I_ack, D_rdata, D_ack, M_req, M_we, M_addr, M_wdata, Owner
  );

  modport master (
    output I_req, I_addr, D_req, D_we, D_addr, D_wdata, M_rdata, M_ack,
    input  I_rdata, I_ack, D_rdata, D_ack, M_req, M_we, M_addr, M_wdata, Owner
  );

endinterface

// File: rtl/arb_pick.sv
// Combinational winner select for the fetch/data arbiter.
// Ports:
//   i_req, d_req : raw requests from the fetch and data ports
//   excl         : current owner, whose own request is ignored (it is completing)
//   force_i      : starvation override, makes I win over D
//   winner       : next owner (OWN_NONE / OWN_I / OWN_D)
module arb_pick
  import mach_v_bus_pkg::*;
(
  input  logic       i_req,
  input  logic       d_req,
  input  logic [1:0] excl,
  input  logic       force_i,
  output logic [1:0] winner
);

  logic i_ok;
  logic d_ok;

  assign i_ok = i_req && (excl != OWN_I);
  assign d_ok = d_req && (excl != OWN_D);

  // D normally wins: its instruction is older in the pipe.
  always_comb begin
    winner = OWN_NONE;
    if (d_ok && !(force_i && i_ok)) begin
      winner = OWN_D;
    end else if (i_ok) begin
      winner = OWN_I;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory bus between the instruction fetch port (I)
// and the LSU data port (D). The grant is registered; the owner's request is
// forwarded combinationally to memory, and the memory ack/rdata is returned
// only to the owner. On the ack cycle the next owner is chosen, so
// back-to-back grants carry no idle cycle.
// Ports:
//   CLK    : rising-edge clock
//   RESETn : asynchronous active-low reset
//   bus    : mem_port_arbiter_if.slave (I_*, D_*, M_*, Owner)
// Build option:
//   ARB_STARVE_GUARD_EN : after STARVE_LIMIT consecutive D grants issued while
//                         I_req is high, the next arbitration goes to I.
//                         Undefined: strict D priority, no counter.
module mem_port_arbiter
  import mach_v_bus_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
`ifdef ARB_STARVE_GUARD_EN
  ,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
`endif
)
(
  input logic              CLK,
  input logic              RESETn,
  mem_port_arbiter_if.slave bus
);

  state_t              state;
  state_t              state_next;
  logic [1:0]          pick;
  logic                arbitrate;
  logic                force_i;
  logic                i_ack;
  logic                d_ack;
  logic [DATA_W/8-1:0] m_we;
  logic [ADDR_W-1:0]   m_addr;
  logic [DATA_W-1:0]   m_wdata;

  // The bus is up for grabs when idle or while the owner is being acked.
  assign arbitrate = (state == IDLE) || bus.M_ack;

  arb_pick u_pick (
    .i_req   (bus.I_req),
    .d_req   (bus.D_req),
    .excl    (state),
    .force_i (force_i),
    .winner  (pick)
  );

`ifdef ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  logic [CNT_W-1:0] starve_cnt;

  assign force_i = (starve_cnt == CNT_W'(STARVE_LIMIT));

  // Counts D grants handed out while I waits; any I grant clears it.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      starve_cnt <= '0;
    end else if (arbitrate && (pick == OWN_I)) begin
      starve_cnt <= '0;
    end else if (arbitrate && (pick == OWN_D) && bus.I_req && !force_i) begin
      starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end
`else
  assign force_i = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Without an ack the owner keeps the bus, even if its request dropped.
  always_comb begin
    state_next = state;
    if (arbitrate) begin
      state_next = state_t'(pick);
    end
  end

  always_comb begin
    m_we    = '0;
    m_addr  = '0;
    m_wdata = '0;
    unique case (state)
      GNT_I: m_addr = bus.I_addr;
      GNT_D: begin
        m_we    = bus.D_we;
        m_addr  = bus.D_addr;
        m_wdata = bus.D_wdata;
      end
      default: ;
    endcase
  end

  // An ack to a port that has already dropped its request is discarded.
  assign i_ack = (state == GNT_I) && bus.M_ack && bus.I_req;
  assign d_ack = (state == GNT_D) && bus.M_ack && bus.D_req;

  assign bus.M_req   = (state != IDLE);
  assign bus.M_we    = m_we;
  assign bus.M_addr  = m_addr;
  assign bus.M_wdata = m_wdata;
  assign bus.I_ack   = i_ack;
  assign bus.D_ack   = d_ack;
  assign bus.I_rdata = i_ack ? bus.M_rdata : '0;
  assign bus.D_rdata = d_ack ? bus.M_rdata : '0;
  assign bus.Owner   = state;

`ifndef SYNTHESIS
  // Requests must be held until acked; a drop is flagged, the arbiter recovers.
  assert property (@(posedge CLK) disable iff (!RESETn) (state == GNT_I) |-> bus.I_req)
    else $warning("mem_port_arbiter: I_req dropped before I_ack");
  assert property (@(posedge CLK) disable iff (!RESETn) (state == GNT_D) |-> bus.D_req)
    else $warning("mem_port_arbiter: D_req dropped before D_ack");
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, reset,
// alternation and protocol-violation sequences, then randomized traffic
// against a transaction-level reference model.
module tb_mem_port_arbiter;
  import mach_v_bus_pkg::*;

  typedef struct packed {
    logic        i_req;
    logic [31:0] i_addr;
    logic        d_req;
    logic [3:0]  d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        m_ack;
    logic [31:0] m_rdata;
  } in_t;

  typedef struct packed {
    logic [1:0]  owner;
    logic        m_req;
    logic [3:0]  m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        d_ack;
    logic [31:0] d_rdata;
  } out_t;

  typedef struct {
    in_t  stim;
    out_t exp;
  } vec_t;

  logic CLK;
  logic RESETn;
  int   testsRun;
  int   failures;

  int   mOwner;
`ifdef ARB_STARVE_GUARD_EN
  localparam int LIMIT = 4;
  int   mStarve;
`endif

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter dut (
    .CLK    (CLK),
    .RESETn (RESETn),
    .bus    (bus)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic in_t mkIn(logic ir, logic [31:0] ia, logic dr, logic [3:0] dwe,
                               logic [31:0] da, logic [31:0] dwd, logic ma, logic [31:0] mrd);
    in_t s;
    s.i_req = ir;  s.i_addr = ia;  s.d_req = dr;  s.d_we = dwe;
    s.d_addr = da; s.d_wdata = dwd; s.m_ack = ma; s.m_rdata = mrd;
    return s;
  endfunction

  function automatic out_t mkOut(logic [1:0] own, logic mr, logic [3:0] mwe, logic [31:0] mad,
                                 logic [31:0] mwd, logic ia, logic [31:0] ird, logic da,
                                 logic [31:0] drd);
    out_t e;
    e.owner = own; e.m_req = mr; e.m_we = mwe; e.m_addr = mad; e.m_wdata = mwd;
    e.i_ack = ia;  e.i_rdata = ird; e.d_ack = da; e.d_rdata = drd;
    return e;
  endfunction

  // Reference: whoever owns the bus sees its request mirrored to memory and
  // gets the ack; on completion (or when idle) the next owner is D if D is
  // asking and is not the one finishing, else I under the same rule.
  function automatic out_t modelStep(input in_t s);
    out_t e;
    bit   iWant;
    bit   dWant;
    int   next;
    e = '0;
    e.owner = 2'(mOwner);
    e.m_req = (mOwner != 0);
    if (mOwner == 1) e.m_addr = s.i_addr;
    if (mOwner == 2) begin
      e.m_addr  = s.d_addr;
      e.m_we    = s.d_we;
      e.m_wdata = s.d_wdata;
    end
    e.i_ack = (mOwner == 1) && s.m_ack && s.i_req;
    e.d_ack = (mOwner == 2) && s.m_ack && s.d_req;
    if (e.i_ack) e.i_rdata = s.m_rdata;
    if (e.d_ack) e.d_rdata = s.m_rdata;
    if ((mOwner == 0) || s.m_ack) begin
      iWant = s.i_req && (mOwner != 1);
      dWant = s.d_req && (mOwner != 2);
      next  = dWant ? 2 : (iWant ? 1 : 0);
`ifdef ARB_STARVE_GUARD_EN
      if ((mStarve >= LIMIT) && iWant) next = 1;
      if ((next == 2) && s.i_req) mStarve = (mStarve < LIMIT) ? mStarve + 1 : LIMIT;
      if (next == 1) mStarve = 0;
`endif
      mOwner = next;
    end
    return e;
  endfunction

  task automatic applyStimulus(input in_t s);
    bus.I_req   = s.i_req;
    bus.I_addr  = s.i_addr;
    bus.D_req   = s.d_req;
    bus.D_we    = s.d_we;
    bus.D_addr  = s.d_addr;
    bus.D_wdata = s.d_wdata;
    bus.M_ack   = s.m_ack;
    bus.M_rdata = s.m_rdata;
  endtask

  task automatic checkOutput(input string name, input out_t exp);
    out_t got;
    got = mkOut(bus.Owner, bus.M_req, bus.M_we, bus.M_addr, bus.M_wdata,
                bus.I_ack, bus.I_rdata, bus.D_ack, bus.D_rdata);
    testsRun++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got owner=%b m_req=%b m_we=%h m_addr=%h m_wdata=%h i_ack=%b i_rdata=%h d_ack=%b d_rdata=%h, expected owner=%b m_req=%b m_we=%h m_addr=%h m_wdata=%h i_ack=%b i_rdata=%h d_ack=%b d_rdata=%h",
               name, got.owner, got.m_req, got.m_we, got.m_addr, got.m_wdata, got.i_ack,
               got.i_rdata, got.d_ack, got.d_rdata, exp.owner, exp.m_req, exp.m_we,
               exp.m_addr, exp.m_wdata, exp.i_ack, exp.i_rdata, exp.d_ack, exp.d_rdata);
    end
  endtask

  // Called at posedge+1: drive, settle, check, advance to next posedge+1.
  task automatic runCycle(input in_t s, input out_t e, input string name);
    applyStimulus(s);
    #3;
    checkOutput(name, e);
    @(posedge CLK);
    #1;
  endtask

  vec_t tbl[13];
  out_t z;
  in_t  zi;
  in_t  s;
  out_t e;
  bit   iPend;
  bit   dPend;

  initial begin
    testsRun = 0;
    failures = 0;
    z  = '0;
    zi = '0;

    // Fetch only, memory acks on the first M_req cycle.
    tbl[0]  = '{mkIn(1'b1, 32'h00400000, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0), z};
    tbl[1]  = '{mkIn(1'b1, 32'h00400000, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 32'h00000013),
                mkOut(OWN_I, 1'b1, 4'h0, 32'h00400000, 32'h0, 1'b1, 32'h00000013, 1'b0, 32'h0)};
    tbl[2]  = '{mkIn(1'b0, 32'h00400000, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h00000055), z};
    // Simultaneous requests: D first, then I with no bubble.
    tbl[3]  = '{mkIn(1'b1, 32'h00400004, 1'b1, 4'hF, 32'h10010000, 32'hDEADBEEF, 1'b0, 32'h0), z};
    tbl[4]  = '{mkIn(1'b1, 32'h00400004, 1'b1, 4'hF, 32'h10010000, 32'hDEADBEEF, 1'b1, 32'h11111111),
                mkOut(OWN_D, 1'b1, 4'hF, 32'h10010000, 32'hDEADBEEF, 1'b0, 32'h0, 1'b1, 32'h11111111)};
    tbl[5]  = '{mkIn(1'b1, 32'h00400004, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 32'h00000022),
                mkOut(OWN_I, 1'b1, 4'h0, 32'h00400004, 32'h0, 1'b1, 32'h00000022, 1'b0, 32'h0)};
    tbl[6]  = '{zi, z};
    // D read with three wait states.
    tbl[7]  = '{mkIn(1'b0, 32'h0, 1'b1, 4'h0, 32'h10010040, 32'h0, 1'b0, 32'h0), z};
    tbl[8]  = '{mkIn(1'b0, 32'h0, 1'b1, 4'h0, 32'h10010040, 32'h0, 1'b0, 32'h00000077),
                mkOut(OWN_D, 1'b1, 4'h0, 32'h10010040, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0)};
    tbl[9]  = tbl[8];
    tbl[10] = tbl[8];
    tbl[11] = '{mkIn(1'b0, 32'h0, 1'b1, 4'h0, 32'h10010040, 32'h0, 1'b1, 32'h0BADF00D),
                mkOut(OWN_D, 1'b1, 4'h0, 32'h10010040, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0BADF00D)};
    tbl[12] = '{zi, z};

    // Reset with requests and an ack present must keep everything quiet.
    RESETn = 1'b0;
    applyStimulus(mkIn(1'b1, 32'h1234, 1'b1, 4'hF, 32'h5678, 32'h9, 1'b1, 32'hFFFF));
    @(posedge CLK);
    #4;
    checkOutput("reset", z);
    applyStimulus(zi);
    RESETn = 1'b1;
    @(posedge CLK);
    #1;

    for (int k = 0; k < 13; k++) begin
      runCycle(tbl[k].stim, tbl[k].exp, $sformatf("vec%0d", k));
    end

    // Reset while D waits for memory: bus drops at once, I is served afterwards.
    s = mkIn(1'b0, 32'h0, 1'b1, 4'h0, 32'h10010080, 32'h0, 1'b0, 32'h0);
    runCycle(s, z, "rst_req_idle");
    applyStimulus(s);
    #3;
    checkOutput("rst_gnt_d", mkOut(OWN_D, 1'b1, 4'h0, 32'h10010080, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0));
    applyStimulus(mkIn(1'b1, 32'h00400008, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0));
    RESETn = 1'b0;
    #1;
    checkOutput("rst_async", z);
    @(posedge CLK);
    #1;
    RESETn = 1'b1;
    s = mkIn(1'b1, 32'h00400008, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    runCycle(s, z, "rst_idle");
    s.m_ack = 1'b1;
    s.m_rdata = 32'h000000A5;
    runCycle(s, mkOut(OWN_I, 1'b1, 4'h0, 32'h00400008, 32'h0, 1'b1, 32'h000000A5, 1'b0, 32'h0),
             "rst_regrant");
    runCycle(zi, z, "rst_done");

    // Both ports request continuously with zero-wait memory: grants alternate.
    s = mkIn(1'b1, 32'h00400100, 1'b1, 4'h3, 32'h10020000, 32'h12345678, 1'b0, 32'h0);
    runCycle(s, z, "alt_idle");
    for (int k = 0; k < 8; k++) begin
      s.m_ack   = 1'b1;
      s.m_rdata = 32'hC0DE0000 + k;
      s.d_req   = (k != 7);
      if ((k % 2) == 0)
        e = mkOut(OWN_D, 1'b1, 4'h3, 32'h10020000, 32'h12345678, 1'b0, 32'h0, 1'b1, s.m_rdata);
      else
        e = mkOut(OWN_I, 1'b1, 4'h0, 32'h00400100, 32'h0, 1'b1, s.m_rdata, 1'b0, 32'h0);
      runCycle(s, e, $sformatf("alt%0d", k));
    end
    runCycle(zi, z, "alt_done");

    // I drops its request before the ack: bus held, ack discarded.
    s = mkIn(1'b1, 32'h0040000C, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    runCycle(s, z, "viol_idle");
    e = mkOut(OWN_I, 1'b1, 4'h0, 32'h0040000C, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    runCycle(s, e, "viol_gnt");
    s.i_req = 1'b0;
    runCycle(s, e, "viol_hold");
    s.m_ack = 1'b1;
    s.m_rdata = 32'h00000099;
    runCycle(s, e, "viol_discard");
    runCycle(zi, z, "viol_after");

    // Randomized protocol-respecting traffic against the reference model.
    mOwner = 0;
`ifdef ARB_STARVE_GUARD_EN
    mStarve = 0;
`endif
    iPend = 1'b0;
    dPend = 1'b0;
    s = zi;
    for (int n = 0; n < 3000; n++) begin
      if (!iPend && ($urandom_range(0, 2) == 0)) begin
        iPend    = 1'b1;
        s.i_addr = $urandom;
      end
      if (!dPend && ($urandom_range(0, 2) == 0)) begin
        dPend     = 1'b1;
        s.d_addr  = $urandom;
        s.d_we    = 4'($urandom_range(0, 15));
        s.d_wdata = $urandom;
      end
      s.i_req   = iPend;
      s.d_req   = dPend;
      s.m_ack   = (mOwner != 0) && ($urandom_range(0, 1) == 1);
      s.m_rdata = $urandom;
      e = modelStep(s);
      runCycle(s, e, "rand");
      if (e.i_ack) iPend = 1'b0;
      if (e.d_ack) dPend = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, failures);
    $finish;
  end

endmodule
